bcd_ms_timer: RTL

Millisecond reaction-time counter, the stage directly upstream of the per-digit 7-segment BCD decoders. Counts elapsed time as four packed BCD digits (format S.mmm, 0.000–9.999 s) under start/stop/clear control. Drives one 4-bit digit value and one decimal-point enable per display position. Digits are always 0–9, except in the blanked-overflow configuration, where they are 4'hF; the downstream decoder renders 4'hF dark.

---
 rtl/bcd_ms_timer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bcd_ms_timer.sv
// bcd_ms_timer -- millisecond reaction-time counter feeding the 7-segment BCD decoders.
//
// Counts elapsed time as four BCD digits (S.mmm, 0.000 .. 9.999) under
// start/stop/clear control. Every output comes straight from a flop.
//
// Optional build macro: BCD_TIMER_OVF_BLANK_EN
//   defined   : in OVF the digits read 4'hF and dp reads 4'b0000, so the display goes dark
//               (the internal count still holds 9999)
//   undefined : OVF shows 9.999 with the decimal point lit
//
// Parameters
//   CLK_HZ, TICK_HZ : clock and count rates; DIV = CLK_HZ/TICK_HZ, an integer >= 2
// Ports
//   clk             : system clock, rising edge
//   rst_n           : asynchronous active-low reset; its release is synchronized
//   clear           : synchronous return to IDLE with count 0000 (highest priority)
//   start           : start/restart request (beats nothing; stop beats it)
//   stop            : stop request (only acts in RUN)
//   digit0..digit3  : ms units, ms tens, ms hundreds, seconds
//   dp              : decimal-point enables, bit n belongs to digitn
//   running         : high in RUN
//   overflow        : high in OVF
module bcd_ms_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] dp,
    output logic       running,
    output logic       overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PSC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_OVF} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0][3:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [PW-1:0]   r_psc, w_psc_nxt;
    logic [3:0][3:0] r_dout, w_dout_nxt;
    logic [3:0]      r_dp, w_dp_nxt;
    logic            r_running, r_overflow;
    logic            r_rst_ok;
    logic            w_carry;
    logic            w_tick;
    logic            w_cnt_max;

    // Release qualifier: the edge that first sees rst_n high only arms this flop,
    // so the second rising edge after deassertion is the first functional one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_ok <= 1'b0;
        else        r_rst_ok <= 1'b1;
    end

    // BCD increment, ripple carry from ms units up to seconds.
    always_comb begin
        w_cnt_inc = r_cnt;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_cnt[i] == 4'd9) begin
                    w_cnt_inc[i] = 4'd0;
                end else begin
                    w_cnt_inc[i] = r_cnt[i] + 4'd1;
                    w_carry      = 1'b0;
                end
            end
        end
    end

    assign w_tick    = (r_psc == PSC_MAX);
    assign w_cnt_max = (r_cnt == 16'h9999);

    // Next state / count / prescaler. Priority: clear > stop > start > counting.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_psc_nxt   = r_psc;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_psc_nxt   = '0;
        end else if (stop) begin
            // A tick landing on the stop edge is dropped: count stays as it was.
            if (r_state == S_RUN) w_state_nxt = S_HOLD;
        end else if (start && r_state != S_RUN) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_psc_nxt   = '0;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                w_psc_nxt = '0;
                if (w_cnt_max) w_state_nxt = S_OVF;
                else           w_cnt_nxt   = w_cnt_inc;
            end else begin
                w_psc_nxt = r_psc + PW'(1);
            end
        end
    end

    // Display image for the next cycle, so the outputs can be flops.
    always_comb begin
        w_dout_nxt = w_cnt_nxt;
        w_dp_nxt   = 4'b1000;
`ifdef BCD_TIMER_OVF_BLANK_EN
        if (w_state_nxt == S_OVF) begin
            w_dout_nxt = 16'hFFFF;
            w_dp_nxt   = 4'b0000;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_psc      <= '0;
            r_dout     <= '0;
            r_dp       <= 4'b1000;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_rst_ok) begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_psc      <= w_psc_nxt;
            r_dout     <= w_dout_nxt;
            r_dp       <= w_dp_nxt;
            r_running  <= (w_state_nxt == S_RUN);
            r_overflow <= (w_state_nxt == S_OVF);
        end
    end

    assign digit0   = r_dout[0];
    assign digit1   = r_dout[1];
    assign digit2   = r_dout[2];
    assign digit3   = r_dout[3];
    assign dp       = r_dp;
    assign running  = r_running;
    assign overflow = r_overflow;

endmodule
